// File: rtl/load_issue_arbiter_pkg.sv
// Shared types for the load issue path.
//   br_mask_t          : one bit per in-flight branch.
//   load_addr_packet_t : packet handed to load_addr_stage.
//   NOP_LOAD_ADDR_PACKET : all-zero packet, valid = 0.
package load_issue_arbiter_pkg;

  localparam int BR_MASK_W = 8;
  localparam int PREG_W    = 6;
  localparam int ADDR_W    = 32;

  typedef logic [BR_MASK_W-1:0] br_mask_t;

  typedef struct packed {
    logic              valid;
    br_mask_t          bm;            // branches this load depends on
    logic [PREG_W-1:0] dest_reg_idx;
    logic [ADDR_W-1:0] base_addr;
  } load_addr_packet_t;

  localparam load_addr_packet_t NOP_LOAD_ADDR_PACKET = '0;

endpackage

// File: rtl/load_issue_arbiter_if.sv
// Bundle between the load requesters, the issue arbiter and load_addr_stage.
// Handshake: a requester holds req_valid/req_packet until it sees req_grant
// in the same cycle; req_grant is the accept and the packet is registered into
// out_packet on that clock edge. out_packet is held while
// load_addr_backpressure is high and out_packet.valid is set.
//   slave  : arbiter side (drives req_grant, out_packet).
//   master : requester / downstream / branch-unit side.
interface load_issue_arbiter_if
  import load_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  load_addr_packet_t  req_packet [NUM_REQ];
  logic [NUM_REQ-1:0] req_grant;
  load_addr_packet_t  out_packet;
  logic               load_addr_backpressure;
  logic               squash_valid;
  br_mask_t           squash_mask;
  logic               resolve_valid;
  br_mask_t           resolve_mask;

  modport slave (
    input  req_valid, req_packet, load_addr_backpressure,
    input  squash_valid, squash_mask, resolve_valid, resolve_mask,
    output req_grant, out_packet
  );

  modport master (
    output req_valid, req_packet, load_addr_backpressure,
    output squash_valid, squash_mask, resolve_valid, resolve_mask,
    input  req_grant, out_packet
  );
endinterface

// File: rtl/load_issue_arbiter_rr.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted bit
//   any_grant : some request was granted
module load_issue_arbiter_rr #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  int idx;

  // Scan ptr, ptr+1, ... wrapping; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/load_issue_arbiter.sv
// Round-robin issue arbiter and issue register in front of load_addr_stage.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus          : requester / downstream / branch signals (slave side)
//   rr_ptr_dbg   : current round-robin priority pointer
module load_issue_arbiter
  import load_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  load_issue_arbiter_if.slave   bus,
  output logic [PW-1:0]         rr_ptr_dbg
);

  load_addr_packet_t  out_q, next_pkt;
  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] eligible, arb_req, grant;
  logic [PW-1:0]      grant_idx;
  logic               any_grant;
  logic               held_kill, slot_free;

  // A request whose own packet depends on the mispredicted branch is never
  // eligible; a req_valid without packet.valid is ignored as well.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] & bus.req_packet[i].valid &
                    ~(bus.squash_valid & |(bus.req_packet[i].bm & bus.squash_mask));
    end
  end

  // Squash is checked against the pre-resolve bm of the held packet.
  assign held_kill = out_q.valid & bus.squash_valid & |(out_q.bm & bus.squash_mask);
  assign slot_free = ~out_q.valid | ~bus.load_addr_backpressure | held_kill;

  // Gating with reset keeps req_grant low while reset is asserted.
  assign arb_req = (slot_free & reset) ? eligible : '0;

  load_issue_arbiter_rr #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    next_pkt = NOP_LOAD_ADDR_PACKET;
    if (any_grant) begin
      next_pkt = bus.req_packet[grant_idx];
      if (bus.resolve_valid) next_pkt.bm = next_pkt.bm & ~bus.resolve_mask;
    end else if (!slot_free) begin
      next_pkt = out_q;
      if (bus.resolve_valid) next_pkt.bm = next_pkt.bm & ~bus.resolve_mask;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q  <= NOP_LOAD_ADDR_PACKET;
      rr_ptr <= '0;
    end else begin
      out_q <= next_pkt;
      if (any_grant) begin
        rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

  assign bus.req_grant  = grant;
  assign bus.out_packet = out_q;
  assign rr_ptr_dbg     = rr_ptr;

endmodule

// File: tb/tb_load_issue_arbiter.sv
module tb_load_issue_arbiter;
  import load_issue_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int PKT_W = $bits(load_addr_packet_t);

  typedef struct {
    logic [N-1:0]      rv;   // req_valid
    logic [N-1:0]      pv;   // per-requester packet.valid
    logic [N-1:0][7:0] bm;   // per-requester bm
    logic              bp;
    logic              sq;
    logic [7:0]        sqm;
    logic              rs;
    logic [7:0]        rsm;
    logic [N-1:0]      eg;   // expected req_grant
    load_addr_packet_t eo;   // expected out_packet after the edge
  } vec_t;

  logic       clock;
  logic       reset;
  logic [1:0] rr_ptr_dbg;

  load_issue_arbiter_if #(.NUM_REQ(N)) bus ();

  load_issue_arbiter #(.NUM_REQ(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [PKT_W-1:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic load_addr_packet_t pkt(input int i, input logic [7:0] bm);
    load_addr_packet_t p;
    p              = '0;
    p.valid        = 1'b1;
    p.bm           = bm;
    p.dest_reg_idx = 6'(10 + i);
    p.base_addr    = 32'h1000 * (i + 1);
    return p;
  endfunction

  function automatic vec_t mv(input logic [3:0] rv, input logic [3:0] pv,
                              input logic [31:0] bm, input logic bp,
                              input logic sq, input logic [7:0] sqm,
                              input logic rs, input logic [7:0] rsm,
                              input logic [3:0] eg, input load_addr_packet_t eo);
    vec_t v;
    v.rv = rv; v.pv = pv; v.bm = bm; v.bp = bp; v.sq = sq; v.sqm = sqm;
    v.rs = rs; v.rsm = rsm; v.eg = eg; v.eo = eo;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    bus.req_valid              = v.rv;
    for (int i = 0; i < N; i++) begin
      bus.req_packet[i]       = pkt(i, v.bm[i]);
      bus.req_packet[i].valid = v.pv[i];
    end
    bus.load_addr_backpressure = v.bp;
    bus.squash_valid           = v.sq;
    bus.squash_mask            = v.sqm;
    bus.resolve_valid          = v.rs;
    bus.resolve_mask           = v.rsm;
  endtask

  // Called just after a rising edge: drive, check grant at the falling edge,
  // then check the registered packet just after the next rising edge.
  task automatic apply(input int k, input vec_t v);
    logic [PKT_W-1:0] e;
    drive(v);
    exp_q.push_back(v.eo);
    @(negedge clock);
    check($sformatf("grant[%0d]", k), 64'(bus.req_grant), 64'(v.eg));
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("queue_empty[%0d]", k), 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check($sformatf("out_packet[%0d]", k), 64'(bus.out_packet), 64'(e));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    load_addr_packet_t nop;
    vec_t v;
    nop = NOP_LOAD_ADDR_PACKET;

    // Fairness with wrap 3 -> 0
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0001, pkt(0, 8'h0)));
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0010, pkt(1, 8'h0)));
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0100, pkt(2, 8'h0)));
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b1000, pkt(3, 8'h0)));
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0001, pkt(0, 8'h0)));
    // Backpressure hold for 3 cycles, then release grants in the same cycle
    for (int i = 0; i < 3; i++)
      vecs.push_back(mv(4'hF, 4'hF, 32'h0, 1, 0, 8'h0, 0, 8'h0, 4'b0000, pkt(0, 8'h0)));
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0010, pkt(1, 8'h0)));
    // Resolve on held packet bm=03 clears bit 0
    vecs.push_back(mv(4'h4, 4'hF, 32'h0003_0000, 0, 0, 8'h0, 0, 8'h0, 4'b0100, pkt(2, 8'h03)));
    vecs.push_back(mv(4'hF, 4'hF, 32'h0, 1, 0, 8'h0, 1, 8'h01, 4'b0000, pkt(2, 8'h02)));
    // Held squash frees the slot under backpressure
    vecs.push_back(mv(4'h8, 4'hF, 32'h0400_0000, 0, 0, 8'h0, 0, 8'h0, 4'b1000, pkt(3, 8'h04)));
    vecs.push_back(mv(4'h4, 4'hF, 32'h0, 1, 1, 8'h04, 0, 8'h0, 4'b0100, pkt(2, 8'h0)));
    // Request squash: req 0 killed twice, never issued
    vecs.push_back(mv(4'h8, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b1000, pkt(3, 8'h0)));
    vecs.push_back(mv(4'h3, 4'hF, 32'h0000_0001, 0, 1, 8'h01, 0, 8'h0, 4'b0010, pkt(1, 8'h0)));
    vecs.push_back(mv(4'h3, 4'hF, 32'h0000_0001, 0, 1, 8'h01, 0, 8'h0, 4'b0010, pkt(1, 8'h0)));
    // req_valid without packet.valid
    vecs.push_back(mv(4'h1, 4'hE, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0000, nop));
    // Backpressure ignored with an empty slot
    vecs.push_back(mv(4'h4, 4'hF, 32'h0003_0000, 1, 0, 8'h0, 0, 8'h0, 4'b0100, pkt(2, 8'h03)));
    // Squash and resolve on the same bit: squash sees pre-clear bm
    vecs.push_back(mv(4'h0, 4'hF, 32'h0, 1, 1, 8'h02, 1, 8'h02, 4'b0000, nop));
    // Resolve clears bm of the packet being granted
    vecs.push_back(mv(4'h1, 4'hF, 32'h0000_0005, 0, 0, 8'h0, 1, 8'h04, 4'b0001, pkt(0, 8'h01)));
    vecs.push_back(mv(4'h2, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0010, pkt(1, 8'h0)));

    // Reset
    drive(mv(4'h0, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0000, nop));
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_out", 64'(bus.out_packet), 64'(nop));
    check("reset_ptr", 64'(rr_ptr_dbg), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < vecs.size(); k++) apply(k, vecs[k]);

    // Reset mid-operation with a valid packet held and requests present
    bus.req_valid = 4'hF;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_packet.valid), 64'(0));
    check("midrst_ptr", 64'(rr_ptr_dbg), 64'(0));
    check("midrst_grant", 64'(bus.req_grant), 64'(0));
    bus.req_valid = 4'h0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    v = mv(4'hF, 4'hF, 32'h0, 0, 0, 8'h0, 0, 8'h0, 4'b0001, pkt(0, 8'h0));
    apply(100, v);
    check("post_rst_ptr", 64'(rr_ptr_dbg), 64'(1));

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
